// File: rtl/serial_tx.sv
// serial_tx: UART transmitter.
// Accepts one parallel word over a valid/ready handshake and sends it as an
// asynchronous frame: start bit, data LSB first, optional parity, then stop
// bit(s). Every bit is held for DIVISOR clk_in cycles. The line output is
// registered, so it never glitches.
module serial_tx #(
    parameter int DIVISOR     = 10416,
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int STOP_BITS   = 1,
    parameter int COUNT_WIDTH = $clog2(DIVISOR),
    parameter int IND_WIDTH   = $clog2(DATA_WIDTH)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    output logic                  data_out,
    output logic                  busy_out
);

    // A one-bit data word would give a zero-width index, so keep at least one bit.
    localparam int IW = (IND_WIDTH < 1) ? 1 : IND_WIDTH;

    localparam logic [COUNT_WIDTH-1:0] CNT_LAST  = COUNT_WIDTH'(DIVISOR - 1);
    localparam logic [IW-1:0]          DATA_LAST = IW'(DATA_WIDTH - 1);
    localparam logic [IW-1:0]          STOP_LAST = IW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                  state;
    logic [COUNT_WIDTH-1:0]  cnt;
    logic [IW-1:0]           idx;
    logic [DATA_WIDTH-1:0]   shreg;
    logic                    par;
    logic                    bit_done;

    // The last cycle of the current bit slot.
    assign bit_done = (cnt == CNT_LAST);

    // busy_out is the complement of the registered ready_out.
    assign busy_out = ~ready_out;

    // Frame sequencer. Every output is registered, and each line level is
    // loaded one edge before its bit slot begins. idx counts data bits in
    // S_DATA and counts stop bits in S_STOP.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state     <= S_IDLE;
            data_out  <= 1'b1;
            ready_out <= 1'b1;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            par       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    data_out  <= 1'b1;
                    ready_out <= 1'b1;
                    cnt       <= '0;
                    idx       <= '0;
                    if (valid_in && ready_out) begin
                        shreg     <= data_in;
                        par       <= (^data_in) ^ PARITY_ODD[0];
                        state     <= S_START;
                        data_out  <= 1'b0;
                        ready_out <= 1'b0;
                    end
                end

                S_START: begin
                    if (bit_done) begin
                        cnt      <= '0;
                        idx      <= '0;
                        state    <= S_DATA;
                        data_out <= shreg[0];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (bit_done) begin
                        cnt <= '0;
                        if (idx == DATA_LAST) begin
                            idx <= '0;
                            if (PARITY_EN != 0) begin
                                state    <= S_PARITY;
                                data_out <= par;
                            end else begin
                                state    <= S_STOP;
                                data_out <= 1'b1;
                            end
                        end else begin
                            idx      <= idx + 1'b1;
                            data_out <= shreg[idx + 1'b1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_PARITY: begin
                    if (bit_done) begin
                        cnt      <= '0;
                        idx      <= '0;
                        state    <= S_STOP;
                        data_out <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_STOP: begin
                    data_out <= 1'b1;
                    if (bit_done) begin
                        cnt <= '0;
                        if (idx == STOP_LAST) begin
                            idx       <= '0;
                            state     <= S_IDLE;
                            ready_out <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    data_out  <= 1'b1;
                    ready_out <= 1'b1;
                    cnt       <= '0;
                    idx       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: drives several serial_tx configurations from a single clock.
// Each frame is compared slot by slot against a bit list that a reference
// model builds from the byte and the frame format.
module tb_serial_tx;

    localparam int N = 5;
    // Instance 0: plain. 1: even parity. 2: odd parity. 3: two stop bits.
    // 4: full-rate divisor.
    localparam int DIV [N] = '{4, 4, 4, 4, 10416};
    localparam int PEN [N] = '{0, 1, 1, 0, 0};
    localparam int POD [N] = '{0, 0, 1, 0, 0};
    localparam int STB [N] = '{1, 1, 1, 2, 1};

    logic           clk = 1'b0;
    logic [N-1:0]   rst;
    logic [N-1:0]   vin;
    logic [7:0]     din [N];
    wire  [N-1:0]   rdy;
    wire  [N-1:0]   dout;
    wire  [N-1:0]   busy;

    int tests = 0;
    int fails = 0;
    bit exp_q [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        serial_tx #(
            .DIVISOR   (DIV[g]),
            .DATA_WIDTH(8),
            .PARITY_EN (PEN[g]),
            .PARITY_ODD(POD[g]),
            .STOP_BITS (STB[g])
        ) u_dut (
            .clk_in   (clk),
            .rst_in   (rst[g]),
            .data_in  (din[g]),
            .valid_in (vin[g]),
            .ready_out(rdy[g]),
            .data_out (dout[g]),
            .busy_out (busy[g])
        );
    end

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference frame: the list of line levels, one entry per bit slot.
    task automatic build(input int i, input logic [7:0] b);
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int k = 0; k < 8; k++) exp_q.push_back(b[k]);
        if (PEN[i] != 0) exp_q.push_back(bit'(($countones(b) + POD[i]) % 2));
        for (int k = 0; k < STB[i]; k++) exp_q.push_back(1'b1);
    endtask

    // Call at a negedge while instance i is idle. Sends b and checks every slot.
    // With hold=1, valid stays high and data_in shows nxt for the whole frame.
    // The next byte is then accepted on the idle cycle that follows the frame.
    task automatic run_frame(input int i, input logic [7:0] b, input bit hold,
                             input logic [7:0] nxt);
        int m, lo, bad;
        chk($sformatf("u%0d idle_ready", i), int'(rdy[i]), 1);
        build(i, b);
        din[i] = b;
        vin[i] = 1'b1;
        @(negedge clk);
        vin[i] = hold;
        din[i] = hold ? nxt : 8'($urandom);
        for (int s = 0; s < exp_q.size(); s++) begin
            m = 0; lo = 0; bad = 0;
            for (int c = 0; c < DIV[i]; c++) begin
                if (dout[i] == exp_q[s]) m++;
                if (!rdy[i]) lo++;
                if (busy[i] == rdy[i]) bad++;
                if (!hold) begin
                    vin[i] = 1'($urandom_range(0, 1));
                    din[i] = 8'($urandom);
                end
                @(negedge clk);
            end
            chk($sformatf("u%0d byte %h slot %0d line", i, b, s), m, DIV[i]);
            chk($sformatf("u%0d byte %h slot %0d ready_low", i, b, s), lo, DIV[i]);
            chk($sformatf("u%0d byte %h slot %0d busy_inv", i, b, s), bad, 0);
        end
        chk($sformatf("u%0d byte %h gap_line", i, b), int'(dout[i]), 1);
        chk($sformatf("u%0d byte %h gap_ready", i, b), int'(rdy[i]), 1);
        if (!hold) vin[i] = 1'b0;
    endtask

    initial begin
        int cnt;
        logic [7:0] b, nb;
        rst = '1;
        vin = '0;
        for (int i = 0; i < N; i++) din[i] = 8'h00;

        // Reset state, and no handshake is accepted while reset is held
        repeat (2) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("u%0d rst_line", i), int'(dout[i]), 1);
            chk($sformatf("u%0d rst_ready", i), int'(rdy[i]), 1);
            chk($sformatf("u%0d rst_busy", i), int'(busy[i]), 0);
        end
        vin = '1;
        repeat (2) @(negedge clk);
        vin = '0;
        rst = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++)
            chk($sformatf("u%0d post_rst_idle", i), int'(dout[i] & rdy[i]), 1);

        // Directed frames
        run_frame(0, 8'h41, 1'b0, 8'h00);
        run_frame(1, 8'h41, 1'b0, 8'h00);
        run_frame(2, 8'h41, 1'b0, 8'h00);
        run_frame(1, 8'h07, 1'b0, 8'h00);
        run_frame(3, 8'hFF, 1'b0, 8'h00);
        run_frame(0, 8'h55, 1'b1, 8'hAA);
        run_frame(0, 8'hAA, 1'b0, 8'h00);

        // Reset during data bit 3 of 0x41 (that bit is 0)
        din[0] = 8'h41;
        vin[0] = 1'b1;
        @(negedge clk);
        vin[0] = 1'b0;
        repeat (4 * DIV[0] + 1) @(negedge clk);
        chk("u0 pre_rst_bit3", int'(dout[0]), 0);
        rst[0] = 1'b1;
        #1;
        chk("u0 async_rst_line", int'(dout[0]), 1);
        chk("u0 async_rst_ready", int'(rdy[0]), 1);
        @(negedge clk);
        rst[0] = 1'b0;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (dout[0] && rdy[0]) cnt++;
            @(negedge clk);
        end
        chk("u0 idle_after_rst", cnt, 12);
        run_frame(0, 8'h41, 1'b0, 8'h00);

        // Random bytes. Some are chained back-to-back with valid held high.
        for (int i = 0; i < 4; i++) begin
            for (int r = 0; r < 6; r++) begin
                b = 8'($urandom);
                if (r % 3 == 0) begin
                    nb = 8'($urandom);
                    run_frame(i, b, 1'b1, nb);
                    run_frame(i, nb, 1'b0, 8'h00);
                end else begin
                    run_frame(i, b, 1'b0, 8'h00);
                end
            end
        end

        // Full-rate divisor: 0x30 keeps the line low for the start bit plus
        // data bits 0..3, which is 5 bit times. The run stops there.
        din[4] = 8'h30;
        vin[4] = 1'b1;
        @(negedge clk);
        vin[4] = 1'b0;
        cnt = 0;
        while (dout[4] == 1'b0 && cnt < 6 * DIV[4]) begin
            cnt++;
            @(negedge clk);
        end
        chk("u4 low_run", cnt, 5 * DIV[4]);
        chk("u4 bit4_high", int'(dout[4]), 1);
        chk("u4 busy_mid", int'(busy[4]), 1);
        rst[4] = 1'b1;
        @(negedge clk);
        rst[4] = 1'b0;
        chk("u4 rst_ready", int'(rdy[4]), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
